zion_basic_circuit_lib_vld_pipe_dff: RTL

ZION_BASIC_CIRCUIT_LIB_VLD_PIPE_DFF -- requirements
Module: zion_basic_circuit_lib_vld_pipe_dff

---
 rtl/zion_basic_circuit_lib_vld_pipe_pkg.sv | 27 ++
 rtl/zion_basic_circuit_lib_vld_pipe_stage.sv | 62 ++++++
 rtl/zion_basic_circuit_lib_vld_pipe_dff.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/zion_basic_circuit_lib_vld_pipe_pkg.sv
// -----------------------------------------------------------------------------
// zion_basic_circuit_lib_vld_pipe_pkg
//
// Shared constants and helpers for the valid/ready register pipeline
// (zion_basic_circuit_lib_vld_pipe_dff and its per-stage cell).
//
// Contents:
//   VLD_PIPE_DEPTH_MIN / VLD_PIPE_DEPTH_MAX : legal range of the DEPTH parameter
//   vld_pipe_occ_width(depth)               : width of the occupancy count that
//                                             must represent 0..depth
//   vld_pipe_depth_ok(depth)                : 1 when depth is inside the legal range
// -----------------------------------------------------------------------------
package zion_basic_circuit_lib_vld_pipe_pkg;

  localparam int VLD_PIPE_DEPTH_MIN = 1;
  localparam int VLD_PIPE_DEPTH_MAX = 16;

  // The count ranges over 0..depth inclusive, hence depth+1 distinct values.
  function automatic int vld_pipe_occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic vld_pipe_depth_ok(input int depth);
    return (depth >= VLD_PIPE_DEPTH_MIN) && (depth <= VLD_PIPE_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/zion_basic_circuit_lib_vld_pipe_stage.sv
// -----------------------------------------------------------------------------
// zion_basic_circuit_lib_vld_pipe_stage
//
// One register stage of the valid/ready pipeline: a valid flag plus a data
// register, with bubble-collapsing advance logic.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset (vld -> 0, dat -> INI_DATA)
//   flush    : synchronous flush, clears vld and holds dat
//   vld_in   : valid of the upstream neighbour (or the pipeline input)
//   dat_in   : data of the upstream neighbour (or the pipeline input)
//   adv_in   : downstream neighbour can take this stage's contents
//              (for the last stage this is the downstream ready)
//   vld      : registered valid of this stage
//   dat      : registered data of this stage
//   adv      : this stage loads from upstream at the next edge
// -----------------------------------------------------------------------------
module zion_basic_circuit_lib_vld_pipe_stage #(
  parameter int                WIDTH    = 8,
  parameter logic [WIDTH-1:0]  INI_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] dat_in,
  input  logic             adv_in,
  output logic             vld,
  output logic [WIDTH-1:0] dat,
  output logic             adv
);

  logic             vld_q;
  logic [WIDTH-1:0] dat_q;

  // An empty stage can always take a new beat, so bubbles are squeezed out
  // even when the downstream side is stalled.
  assign adv = ~vld_q | adv_in;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= 1'b0;
      dat_q <= INI_DATA;
    end else begin
      if (flush) begin
        vld_q <= 1'b0;
      end else if (adv) begin
        vld_q <= vld_in;
      end
      // Data only moves with a real beat; bubbles and flushes leave it alone,
      // which keeps the data path quiet when nothing is flowing.
      if (adv && vld_in && !flush) begin
        dat_q <= dat_in;
      end
    end
  end

  assign vld = vld_q;
  assign dat = dat_q;

endmodule

// File: rtl/zion_basic_circuit_lib_vld_pipe_dff.sv
// -----------------------------------------------------------------------------
// zion_basic_circuit_lib_vld_pipe_dff
//
// DEPTH-stage valid/ready register pipeline with bubble collapsing, built as a
// generate chain of zion_basic_circuit_lib_vld_pipe_stage cells. Stage 0 is the
// input end; stage DEPTH-1 drives oVld/oDat.
//
// Handshake: a beat moves across an interface on a rising edge where valid and
// ready are both 1 in the preceding cycle; valid never depends on ready of the
// same interface, ready (oRdy) is combinational from iRdy, iFlush, rst and the
// stage valids; data is only meaningful while the matching valid is 1.
//
// Parameters:
//   WIDTH_IN  : input data width
//   WIDTH_OUT : output data width, must equal WIDTH_IN
//   DEPTH     : number of register stages, 1..16
//   INI_DATA  : reset value of every stage data register
//
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-low reset; overrides iFlush and iVld
//   iFlush : synchronous flush; clears all valids, holds data, ignores iVld
//   iVld   : upstream valid
//   oRdy   : upstream ready
//   iDat   : upstream data
//   oVld   : downstream valid (stage DEPTH-1)
//   iRdy   : downstream ready
//   oDat   : downstream data (stage DEPTH-1)
//   oOcc   : number of valid stages (only with ZION_VLD_PIPE_DFF_OCC_EN)
//
// Build options:
//   ZION_VLD_PIPE_DFF_OCC_EN : adds the registered oOcc occupancy output
//   CHECK_ERR_EXIT           : a bad parameter set stops elaboration
// -----------------------------------------------------------------------------
module zion_basic_circuit_lib_vld_pipe_dff
  import zion_basic_circuit_lib_vld_pipe_pkg::*;
#(
  parameter int                   WIDTH_IN  = 8,
  parameter int                   WIDTH_OUT = 8,
  parameter int                   DEPTH     = 2,
  parameter logic [WIDTH_IN-1:0]  INI_DATA  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iFlush,
  input  logic                 iVld,
  output logic                 oRdy,
  input  logic [WIDTH_IN-1:0]  iDat,
  output logic                 oVld,
  input  logic                 iRdy,
  output logic [WIDTH_OUT-1:0] oDat
`ifdef ZION_VLD_PIPE_DFF_OCC_EN
  ,
  output logic [vld_pipe_occ_width(DEPTH)-1:0] oOcc
`endif
);

  // ---------------------------------------------------------------------------
  // Parameter sanity check at elaboration
  // ---------------------------------------------------------------------------
  if ((WIDTH_IN != WIDTH_OUT) || !vld_pipe_depth_ok(DEPTH)) begin : g_param_err
    $error("zion_basic_circuit_lib_vld_pipe_dff: bad parameters WIDTH_IN=%0d WIDTH_OUT=%0d DEPTH=%0d (DEPTH must be %0d..%0d, widths equal)",
           WIDTH_IN, WIDTH_OUT, DEPTH, VLD_PIPE_DEPTH_MIN, VLD_PIPE_DEPTH_MAX);
`ifdef CHECK_ERR_EXIT
    $fatal(1, "zion_basic_circuit_lib_vld_pipe_dff: stopping on bad parameters");
`endif
  end

  // ---------------------------------------------------------------------------
  // Stage chain
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0]    vld;
  logic [DEPTH-1:0]    adv;
  logic [WIDTH_IN-1:0] dat [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic                up_vld;
    logic [WIDTH_IN-1:0] up_dat;
    logic                dn_adv;

    if (k == 0) begin : g_head
      // iVld needs no flush masking here: the stage clears its valid on
      // flush regardless of what it is offered.
      assign up_vld = iVld;
      assign up_dat = iDat;
    end else begin : g_body
      assign up_vld = vld[k-1];
      assign up_dat = dat[k-1];
    end

    if (k == DEPTH - 1) begin : g_tail
      assign dn_adv = iRdy;
    end else begin : g_mid
      assign dn_adv = adv[k+1];
    end

    zion_basic_circuit_lib_vld_pipe_stage #(
      .WIDTH    (WIDTH_IN),
      .INI_DATA (INI_DATA)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .flush  (iFlush),
      .vld_in (up_vld),
      .dat_in (up_dat),
      .adv_in (dn_adv),
      .vld    (vld[k]),
      .dat    (dat[k]),
      .adv    (adv[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The outputs are forced to their reset values while rst is low so that the
  // interface is quiet from the first reset cycle, before any edge has
  // loaded the registers.
  assign oRdy = rst & ~iFlush & adv[0];
  assign oVld = rst & vld[DEPTH-1];
  assign oDat = rst ? dat[DEPTH-1] : INI_DATA;

`ifdef ZION_VLD_PIPE_DFF_OCC_EN
  // ---------------------------------------------------------------------------
  // Occupancy counter
  // ---------------------------------------------------------------------------
  // Bubble collapsing moves beats between stages without changing how many
  // there are, so the valid count only changes by the beats entering at the
  // top and leaving at the bottom. Tracking those two events keeps the count
  // in step with the valids on the same edge without a population count.
  localparam int OCC_W = vld_pipe_occ_width(DEPTH);

  logic [OCC_W-1:0] occ_q;
  logic             beat_in;
  logic             beat_out;

  assign beat_in  = oRdy & iVld;          // oRdy already excludes reset and flush
  assign beat_out = vld[DEPTH-1] & iRdy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_q <= '0;
    end else if (iFlush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OCC_W'(beat_in) - OCC_W'(beat_out);
    end
  end

  assign oOcc = rst ? occ_q : '0;
`endif

endmodule
